// File: rtl/watch_pkg.sv
// Shared types and constants for the lap stopwatch core.
// Optional build macro used by lap_watch_core: KEY_SYNC_EN.
package watch_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECALL = 2'd3
    } state_t;

    // State to return to when recall mode is left.
    typedef enum logic {
        RET_IDLE  = 1'b0,
        RET_PAUSE = 1'b1
    } ret_t;

    typedef struct packed {
        logic start;
        logic load;
        logic recall;
    } keys_t;

    // (a - b) mod m for 0 <= a < m and 0 <= b <= m.
    function automatic int mod_sub(input int a, input int b, input int m);
        int r;
        r = a - b;
        if (r < 0) r += m;
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear and a wrap pulse
// that is high in the cycle where an increment rolls all-9s over to 0.
module bcd_counter
    import watch_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                          clk_50Mhz,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          inc,
    output logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          wrap
);

    logic [DIGIT_W*NUM_DIGITS-1:0] value_nxt;
    logic                          all_max;

    // Next value: ripple a +1 carry from digit 0 upward; clear wins.
    always_comb begin
        logic carry;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        value_nxt = value;
        carry     = inc;
        all_max   = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (value[d*DIGIT_W +: DIGIT_W] != BCD_MAX) all_max = 1'b0;
            if (carry) begin
                if (value[d*DIGIT_W +: DIGIT_W] == BCD_MAX) begin
                    value_nxt[d*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    value_nxt[d*DIGIT_W +: DIGIT_W] = value[d*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (clr) value_nxt = '0;
    end

    assign wrap = inc & all_max & ~clr;

    // Count register.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) value <= '0;
        else      value <= value_nxt;
    end

endmodule

// File: rtl/lap_watch_core.sv
// Stopwatch core: prescaler, key control, BCD count, lap memory with
// recall and a sticky overflow flag. dispbuf feeds the display decoder.
// Build macro KEY_SYNC_EN: when defined, keys are synchronised and
// edge-detected (held key acts once, 3 cycles extra latency); otherwise
// keys are clk-synchronous single-cycle pulses acted on the same edge.
module lap_watch_core
    import watch_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int NUM_DIGITS = 6,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                             clk_50Mhz,
    input  logic                             rst,
    input  logic                             key_start,
    input  logic                             key_load,
    input  logic                             key_recall,
    output logic [4*NUM_DIGITS-1:0]          dispbuf,
    output logic                             running,
    output logic                             recall_active,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic                             overflow
);

    localparam int VAL_W = DIGIT_W * NUM_DIGITS;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    keys_t             keys;
    logic              act_start, act_load, act_recall;
    state_t            state, state_nxt;
    ret_t              ret_state;
    logic [PRE_W-1:0]  presc;
    logic              tick, clear, lap_wr, recall_enter, recall_step;
    logic [VAL_W-1:0]  count_value;
    logic              count_wrap;
    logic [PTR_W-1:0]  wr_ptr, rd_idx, oldest, newest;
    logic              has_laps, rd_at_newest;
    logic [VAL_W-1:0]  lap_ram [LAP_DEPTH];

`ifdef KEY_SYNC_EN
    logic [2:0] key_meta, key_sync, key_prev;
    keys_t      key_pulse;

    // Two-flop synchroniser, edge detector and registered pulse per key.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            key_meta  <= '0;
            key_sync  <= '0;
            key_prev  <= '0;
            key_pulse <= '0;
        end else begin
            key_meta  <= {key_start, key_load, key_recall};
            key_sync  <= key_meta;
            key_prev  <= key_sync;
            key_pulse <= keys_t'(key_sync & ~key_prev);
        end
    end

    assign keys = key_pulse;
`else
    assign keys = '{start: key_start, load: key_load, recall: key_recall};
`endif

    // Only the highest-priority key is acted on: start > load > recall.
    assign act_start  = keys.start;
    assign act_load   = keys.load & ~keys.start;
    assign act_recall = keys.recall & ~keys.load & ~keys.start;

    // Lap ring bookkeeping.
    assign has_laps     = (lap_count != '0);
    assign oldest       = PTR_W'(mod_sub(int'(wr_ptr), int'(lap_count), LAP_DEPTH));
    assign newest       = PTR_W'(mod_sub(int'(wr_ptr), 1, LAP_DEPTH));
    assign rd_at_newest = (rd_idx == newest);

    // State register.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (act_start)                  state_nxt = ST_RUN;
                else if (act_recall && has_laps) state_nxt = ST_RECALL;
            end
            ST_RUN: begin
                if (act_start) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (act_start)                  state_nxt = ST_RUN;
                else if (act_load)              state_nxt = ST_IDLE;
                else if (act_recall && has_laps) state_nxt = ST_RECALL;
            end
            ST_RECALL: begin
                if (act_start || (act_recall && rd_at_newest))
                    state_nxt = (ret_state == RET_PAUSE) ? ST_PAUSE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Action strobes decoded from the current state and accepted key.
    always_comb begin
        tick         = (state == ST_RUN) && (presc == PRE_LAST);
        clear        = (state == ST_PAUSE) && act_load;
        lap_wr       = (state == ST_RUN) && act_load;
        recall_enter = ((state == ST_IDLE) || (state == ST_PAUSE)) && act_recall && has_laps;
        recall_step  = (state == ST_RECALL) && act_recall && !rd_at_newest;
    end

    // Prescaler: runs only in RUN, holds in PAUSE/RECALL, zero in IDLE.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst)                                presc <= '0;
        else if (state == ST_RUN)                presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        else if ((state == ST_IDLE) || clear)    presc <= '0;
    end

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_count (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .clr       (clear),
        .inc       (tick),
        .value     (count_value),
        .wrap      (count_wrap)
    );

    // Sticky overflow: set on wrap, cleared only by clear or reset.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst)            overflow <= 1'b0;
        else if (clear)      overflow <= 1'b0;
        else if (count_wrap) overflow <= 1'b1;
    end

    // Write pointer and number of valid laps (saturating).
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            lap_count <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            lap_count <= '0;
        end else if (lap_wr) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (lap_count != CNT_FULL) lap_count <= lap_count + 1'b1;
        end
    end

    // Lap storage; captures the count as registered this cycle.
    always_ff @(posedge clk_50Mhz) begin
        // NOTE: the lap RAM has no reset; lap_count marks which entries are valid.
        if (lap_wr) lap_ram[wr_ptr] <= count_value;
    end

    // Recall read index and the state to return to.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            rd_idx    <= '0;
            ret_state <= RET_IDLE;
        end else if (recall_enter) begin
            rd_idx    <= oldest;
            ret_state <= (state == ST_PAUSE) ? RET_PAUSE : RET_IDLE;
        end else if (recall_step) begin
            rd_idx <= (rd_idx == PTR_LAST) ? '0 : rd_idx + 1'b1;
        end
    end

    // Registered outputs: display source by state, status flags track state.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            dispbuf       <= '0;
            running       <= 1'b0;
            recall_active <= 1'b0;
        end else begin
            dispbuf       <= (state == ST_RECALL) ? lap_ram[rd_idx] : count_value;
            running       <= (state_nxt == ST_RUN);
            recall_active <= (state_nxt == ST_RECALL);
        end
    end

endmodule

// File: tb/tb_lap_watch_core.sv
// Self-checking bench for lap_watch_core (TICK_DIV=4, NUM_DIGITS=2,
// LAP_DEPTH=2, KEY_SYNC_EN undefined).
module tb_lap_watch_core;

    localparam int TICK_DIV   = 4;
    localparam int NUM_DIGITS = 2;
    localparam int LAP_DEPTH  = 2;
    localparam int MAX_COUNT  = 99;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_RECALL = 3;

    logic       clk_50Mhz = 1'b0;
    logic       rst = 1'b0;
    logic       key_start = 1'b0, key_load = 1'b0, key_recall = 1'b0;
    logic [7:0] dispbuf;
    logic       running, recall_active, overflow;
    logic [1:0] lap_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers and a queue of laps).
    int m_st, m_ret, m_presc, m_count, m_rd, m_disp;
    bit m_ovf;
    int laps[$];

    lap_watch_core #(
        .TICK_DIV   (TICK_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .LAP_DEPTH  (LAP_DEPTH)
    ) dut (
        .clk_50Mhz     (clk_50Mhz),
        .rst           (rst),
        .key_start     (key_start),
        .key_load      (key_load),
        .key_recall    (key_recall),
        .dispbuf       (dispbuf),
        .running       (running),
        .recall_active (recall_active),
        .lap_count     (lap_count),
        .overflow      (overflow)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = M_IDLE; m_ret = M_IDLE; m_presc = 0; m_count = 0;
        m_rd = 0; m_disp = 0; m_ovf = 0;
        laps.delete();
    endfunction

    // One clock edge of the stopwatch rules, with the keys seen at that edge.
    function automatic void model_step(input bit s, input bit l, input bit r);
        int  shown;
        int  cnt_before;
        bit  tick;
        shown      = (m_st == M_RECALL) ? laps[m_rd] : m_count;
        cnt_before = m_count;
        tick       = (m_st == M_RUN) && (m_presc == TICK_DIV - 1);
        if (m_st == M_RUN)       m_presc = (m_presc + 1) % TICK_DIV;
        else if (m_st == M_IDLE) m_presc = 0;
        if (tick) begin
            if (m_count == MAX_COUNT) begin m_count = 0; m_ovf = 1; end
            else m_count++;
        end
        case (m_st)
            M_IDLE: begin
                if (s) m_st = M_RUN;
                else if (!l && r && laps.size() > 0) begin m_ret = M_IDLE; m_rd = 0; m_st = M_RECALL; end
            end
            M_RUN: begin
                if (s) m_st = M_PAUSE;
                else if (l) begin
                    laps.push_back(cnt_before);
                    if (laps.size() > LAP_DEPTH) void'(laps.pop_front());
                end
            end
            M_PAUSE: begin
                if (s) m_st = M_RUN;
                else if (l) begin
                    m_st = M_IDLE; m_count = 0; m_presc = 0; m_ovf = 0;
                    laps.delete();
                end else if (r && laps.size() > 0) begin m_ret = M_PAUSE; m_rd = 0; m_st = M_RECALL; end
            end
            default: begin
                if (s) m_st = m_ret;
                else if (!l && r) begin
                    if (m_rd + 1 >= laps.size()) m_st = m_ret;
                    else m_rd++;
                end
            end
        endcase
        m_disp = shown;
    endfunction

    task automatic compare_model();
        check("disp",    32'(dispbuf),       32'(to_bcd(m_disp)));
        check("running", 32'(running),       32'(m_st == M_RUN));
        check("recall",  32'(recall_active), 32'(m_st == M_RECALL));
        check("lapcnt",  32'(lap_count),     32'(laps.size()));
        check("ovf",     32'(overflow),      32'(m_ovf));
    endtask

    // Drive keys for one cycle (called at a falling edge), then compare.
    task automatic step(input bit s, input bit l, input bit r);
        key_start = s; key_load = l; key_recall = r;
        @(posedge clk_50Mhz);
        @(negedge clk_50Mhz);
        key_start = 0; key_load = 0; key_recall = 0;
        model_step(s, l, r);
        compare_model();
    endtask

    typedef struct {
        bit         s, l, r;
        logic [7:0] disp;
        bit         run, rec;
        int         lc;
        bit         ovf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int c;
        int guard;

        // ---------------- reset ----------------
        model_reset();
        repeat (3) @(negedge clk_50Mhz);
        check("rst_disp",   32'(dispbuf),       0);
        check("rst_run",    32'(running),       0);
        check("rst_recall", 32'(recall_active), 0);
        check("rst_lapcnt", 32'(lap_count),     0);
        check("rst_ovf",    32'(overflow),      0);
        rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0};  // idle
        vecs[1]  = '{0, 1, 0, 8'h00, 0, 0, 0, 0};  // load in IDLE ignored
        vecs[2]  = '{0, 0, 1, 8'h00, 0, 0, 0, 0};  // recall with no laps ignored
        vecs[3]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0};  // start -> RUN
        vecs[4]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0};  // tick edge, display lags
        vecs[8]  = '{0, 0, 0, 8'h01, 1, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 8'h01, 1, 0, 1, 0};  // lap capture
        vecs[10] = '{1, 0, 0, 8'h01, 0, 0, 1, 0};  // pause
        vecs[11] = '{0, 0, 1, 8'h01, 0, 1, 1, 0};  // enter recall
        vecs[12] = '{0, 0, 0, 8'h01, 0, 1, 1, 0};  // shows lap 01
        vecs[13] = '{0, 0, 1, 8'h01, 0, 0, 1, 0};  // past newest -> PAUSE
        vecs[14] = '{0, 1, 0, 8'h01, 0, 0, 0, 0};  // clear -> IDLE
        vecs[15] = '{0, 0, 0, 8'h00, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].s, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d_disp", i),   32'(dispbuf),       32'(vecs[i].disp));
            check($sformatf("vec%0d_run", i),    32'(running),       32'(vecs[i].run));
            check($sformatf("vec%0d_recall", i), 32'(recall_active), 32'(vecs[i].rec));
            check($sformatf("vec%0d_lapcnt", i), 32'(lap_count),     32'(vecs[i].lc));
            check($sformatf("vec%0d_ovf", i),    32'(overflow),      32'(vecs[i].ovf));
        end

        // ---------------- 40 clocks of running -> 10 ----------------
        step(1, 0, 0);
        repeat (41) step(0, 0, 0);
        check("t1_disp", 32'(dispbuf), 32'h10);
        check("t1_run",  32'(running), 1);

        // ---------------- wrap 99 -> 00 and clear ----------------
        guard = 0;
        while (overflow !== 1'b1 && guard < 600) begin step(0, 0, 0); guard++; end
        check("t2_wrap_seen", 32'(overflow), 1);
        check("t2_disp_99",   32'(dispbuf),  32'h99);
        step(0, 0, 0);
        check("t2_disp_00", 32'(dispbuf),  32'h00);
        check("t2_ovf",     32'(overflow), 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("t2_clr_ovf",  32'(overflow), 0);
        check("t2_clr_disp", 32'(dispbuf),  0);
        check("t2_clr_run",  32'(running),  0);

        // ---------------- laps at 03, 07, 12 and recall ----------------
        step(1, 0, 0);
        guard = 0;
        while (m_count != 3 && guard < 100) begin step(0, 0, 0); guard++; end
        step(0, 1, 0);
        while (m_count != 7 && guard < 100) begin step(0, 0, 0); guard++; end
        step(0, 1, 0);
        while (m_count != 12 && guard < 100) begin step(0, 0, 0); guard++; end
        step(0, 1, 0);
        check("t3_lapcnt", 32'(lap_count), 2);
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        check("t3_lap07",    32'(dispbuf),       32'h07);
        check("t3_recall_1", 32'(recall_active), 1);
        step(0, 0, 1);
        step(0, 0, 0);
        check("t3_lap12", 32'(dispbuf), 32'h12);
        step(0, 0, 1);
        check("t3_recall_0", 32'(recall_active), 0);
        step(0, 0, 0);
        check("t3_live", 32'(dispbuf), 32'h12);

        // ---------------- pause/resume keeps tick phase ----------------
        step(0, 1, 0);
        step(1, 0, 0);
        guard = 0;
        while (!(m_presc == 1 && m_count >= 2) && guard < 100) begin step(0, 0, 0); guard++; end
        check("t4_reached", 32'(m_presc == 1), 1);
        c = m_count;
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        check("t4_hold", 32'(dispbuf), 32'(to_bcd(c)));
        step(1, 0, 0);
        step(0, 0, 0);
        check("t4_res1", 32'(dispbuf), 32'(to_bcd(c)));
        step(0, 0, 0);
        check("t4_res2", 32'(dispbuf), 32'(to_bcd(c)));
        step(0, 0, 0);
        check("t4_res3", 32'(dispbuf), 32'(to_bcd(c + 1)));

        // ---------------- start + load together in RUN ----------------
        step(0, 1, 0);
        step(1, 1, 0);
        check("t5_run",    32'(running),   0);
        check("t5_lapcnt", 32'(lap_count), 1);

        // ---------------- asynchronous reset mid-run ----------------
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_disp",   32'(dispbuf),       0);
        check("t6_run",    32'(running),       0);
        check("t6_recall", 32'(recall_active), 0);
        check("t6_lapcnt", 32'(lap_count),     0);
        check("t6_ovf",    32'(overflow),      0);
        model_reset();
        @(negedge clk_50Mhz);
        rst = 1'b1;
        repeat (3) step(0, 0, 0);
        check("t6_idle", 32'(running), 0);
        step(1, 0, 0);
        check("t6_start", 32'(running), 1);

        // ---------------- randomised keys against the model ----------------
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_watch_core.md
Name: lap_watch_core

Overview:
Parametrised next-generation stopwatch core for the DigitalWatch design. It combines the prescaler, key control and counter functions into one block. It adds:
- configurable BCD digit count
- a lap memory of configurable depth, with recall
- a sticky overflow flag

Its output feeds the existing display decoder through dispbuf.

Parameters:
TICK_DIV, 50000, clk_50Mhz cycles per count tick (1 kHz at 50 MHz); minimum 2.
NUM_DIGITS, 6, number of BCD digits in the count; minimum 1.
LAP_DEPTH, 4, number of lap entries stored; minimum 1; need not be a power of 2.

Ports:
clk_50Mhz  in  1  system clock; all logic is on its rising edge.
rst  in  1  asynchronous, active-low reset.
key_start  in  1  run/pause toggle; also exits recall.
key_load  in  1  lap capture while running; clear while paused.
key_recall  in  1  step through stored laps.
dispbuf  out  4*NUM_DIGITS  BCD value to display; digit 0 in bits [3:0].
running  out  1  high in RUN state.
recall_active  out  1  high in RECALL state.
lap_count  out  $clog2(LAP_DEPTH+1)  number of valid lap entries.
overflow  out  1  sticky count wrap flag.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; count, prescaler, lap pointers and lap_count = 0. All outputs = 0. Lap RAM contents are don't-care.
- States: IDLE, RUN, PAUSE, RECALL. A 1-bit ret_state register (IDLE or PAUSE) records the state to return to from RECALL.
- Key priority in the same cycle: start > load > recall. Exactly one key is acted on; the others are dropped.
- Transitions:
  - IDLE + start -> RUN.
  - RUN + start -> PAUSE.
  - PAUSE + start -> RUN.
  - PAUSE + load -> IDLE; clears count, prescaler, overflow, lap_count and pointers.
  - IDLE + load: no effect.
  - RUN + load: lap capture; stays in RUN.
  - IDLE/PAUSE + recall with lap_count>0 -> RECALL; ret_state := current state; rd_idx := oldest entry.
  - IDLE/PAUSE + recall with lap_count=0: ignored.
  - RECALL + recall: advance rd_idx. After the newest entry, the next recall press returns to ret_state.
  - RECALL + start -> ret_state, with no run/pause toggle.
  - RECALL + load: ignored.
  - RUN + recall: ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; wraps to 0.
  - Holds its value in PAUSE and RECALL, so the tick phase is preserved across pause/resume.
  - Cleared in IDLE.
  - Tick = prescaler == TICK_DIV-1 while in RUN.
- Count:
  - Each tick increments the BCD count by 1 on the next edge, with digit-wise carry.
  - All-9s + tick -> all-0s and overflow := 1.
  - overflow is cleared only by clear or reset.
- Lap capture:
  - Writes the count as registered in that cycle (pre-increment if a tick coincides) to RAM[wr_ptr].
  - wr_ptr := (wr_ptr+1) mod LAP_DEPTH.
  - lap_count saturates at LAP_DEPTH. When full, the oldest entry is overwritten.
  - oldest = (wr_ptr - lap_count) mod LAP_DEPTH.
- dispbuf is registered with 1-cycle latency:
  - RECALL: shows RAM[rd_idx].
  - All other states: shows the live count.
- running, recall_active and lap_count are registered and reflect the current state.

Optional Feature:
KEY_SYNC_EN
- Defined: each key passes through a 2-flop synchroniser plus rising-edge detector. A held key acts once. This adds 3 cycles of key-to-action latency.
- Undefined: keys must be single-cycle pulses synchronous to clk_50Mhz and act on the same edge. A key held N cycles acts N times.

Decomposition:
- Package watch_pkg:
  - state enum (IDLE/RUN/PAUSE/RECALL)
  - BCD_MAX = 4'd9
  - digit width constant 4
- Sub-module bcd_counter (parameter NUM_DIGITS):
  - inputs: clk_50Mhz, rst, clr, inc
  - outputs: value, wrap pulse
  - instantiated once.

Test Plan:
(KEY_SYNC_EN off; TICK_DIV=4, NUM_DIGITS=2, LAP_DEPTH=2)
1. Reset, pulse start, wait 40 clocks -> dispbuf=8'h10, running=1.
2. Run until dispbuf=8'h99, wait one more tick -> dispbuf=8'h00, overflow=1. Pause, then load -> overflow=0, dispbuf=0, state IDLE.
3. Press load at counts 03, 07 and 12 -> lap_count=2. Pause, then recall -> 07; recall -> 12; recall -> live count with recall_active=0.
4. Pause when the prescaler=2, resume -> next tick lands exactly 1 clock after resume (prescaler 2->3); count is unchanged while paused.
5. start and load in the same cycle while in RUN -> PAUSE entered, lap_count unchanged.
6. Assert rst low mid-run, between clock edges -> all outputs 0 immediately. Release rst -> IDLE, and start is required to run.
